// File: rtl/pb_ctrl.sv
// Push-button front end: synchronises and debounces an active-low button, then classifies presses.
// Short press -> one-cycle pb_pulse on release; long press -> toggles mode_selection. Build option: PB_AUTOREPEAT_EN.
module pb_ctrl #(
    parameter int DEB_LEN    = 4,
    parameter int LONG_CNT   = 1000,
    parameter int REPEAT_CNT = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in_n,
    output logic pb_pulse,
    output logic mode_selection,
    output logic pb_level
);

    localparam int HOLD_W = $clog2(LONG_CNT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT - 1);

    generate
        if (DEB_LEN < 2 || LONG_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_params
            $error("pb_ctrl: DEB_LEN, LONG_CNT and REPEAT_CNT must all be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic               sync_meta_reg;
    logic               sync_q;
    logic [DEB_LEN-1:0] shift_reg;
    logic               pb_level_next;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    state_t             state_reg;

    // Two-flop synchroniser and debounce shift register, all reset to "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 1'b0;
            sync_q        <= 1'b0;
            shift_reg     <= '0;
            pb_level      <= 1'b0;
        end else begin
            sync_meta_reg <= ~pb_in_n;
            sync_q        <= sync_meta_reg;
            shift_reg     <= {shift_reg[DEB_LEN-2:0], sync_q};
            pb_level      <= pb_level_next;
        end
    end

    always_comb begin
        pb_level_next = pb_level;
        if (&shift_reg) begin
            pb_level_next = 1'b1;
        end else if (~|shift_reg) begin
            pb_level_next = 1'b0;
        end
    end

`ifdef PB_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CNT);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CNT - 1);
    logic [REP_W-1:0] rep_cnt_reg;
`endif

    // IDLE reacts to the debounce set condition so PRESSED starts on the same edge pb_level rises;
    // release is judged on the registered level, so the short-press pulse lands one cycle after pb_level falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            pb_pulse       <= 1'b0;
            mode_selection <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
            rep_cnt_reg    <= '0;
`endif
        end else begin
            pb_pulse <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pb_level_next) begin
                        state_reg    <= PRESSED;
                        hold_cnt_reg <= '0;
                    end
                end
                PRESSED: begin
                    if (!pb_level) begin
                        state_reg <= IDLE;
                        pb_pulse  <= 1'b1;
                    end else if (hold_cnt_reg == HOLD_MAX) begin
                        state_reg      <= LONG;
                        mode_selection <= ~mode_selection;
`ifdef PB_AUTOREPEAT_EN
                        rep_cnt_reg    <= '0;
`endif
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                LONG: begin
                    if (!pb_level) begin
                        state_reg <= IDLE;
`ifdef PB_AUTOREPEAT_EN
                    end else if (rep_cnt_reg == REP_MAX) begin
                        // A repeat that coincides with the debounced release is dropped.
                        rep_cnt_reg <= '0;
                        pb_pulse    <= pb_level_next;
                    end else begin
                        rep_cnt_reg <= rep_cnt_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pb_ctrl.sv
// Directed self-checking bench for pb_ctrl with DEB_LEN=4, LONG_CNT=20, REPEAT_CNT=8.
module tb_pb_ctrl;

`ifdef PB_AUTOREPEAT_EN
    localparam int AR_ON = 1;
`else
    localparam int AR_ON = 0;
`endif

    logic clk;
    logic rst_n;
    logic pb_in_n;
    logic pb_pulse;
    logic mode_selection;
    logic pb_level;

    pb_ctrl #(
        .DEB_LEN   (4),
        .LONG_CNT  (20),
        .REPEAT_CNT(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pb_in_n       (pb_in_n),
        .pb_pulse      (pb_pulse),
        .mode_selection(mode_selection),
        .pb_level      (pb_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   pulse_cnt = 0;
    int   last_pulse_cyc = -1;
    int   rise_cyc = -1;
    int   fall_cyc = -1;
    int   mode_chg_cyc = -1;
    logic lvl_seen = 1'b0;
    logic consec = 1'b0;
    logic prev_pulse = 1'b0;
    logic prev_level = 1'b0;
    logic prev_mode = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int base, t0, t1, r;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: sampled on the falling edge, so cyc is the index of the last rising edge.
    always @(negedge clk) begin
        if (pb_level === 1'b1) lvl_seen <= 1'b1;
        if (pb_pulse === 1'b1) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
            if (prev_pulse) consec <= 1'b1;
        end
        if (pb_level === 1'b1 && !prev_level) rise_cyc <= cyc;
        if (pb_level === 1'b0 && prev_level) fall_cyc <= cyc;
        if (mode_selection !== prev_mode) mode_chg_cyc <= cyc;
        prev_pulse <= pb_pulse;
        prev_level <= pb_level;
        prev_mode  <= mode_selection;
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        pb_in_n = 1'b1;
        ticks(3);
        chk("reset_pb_pulse", 32'(pb_pulse), 0);
        chk("reset_pb_level", 32'(pb_level), 0);
        chk("reset_mode", 32'(mode_selection), 1);
        rst_n = 1'b1;
        ticks(2);

        // Bounce: runs of 3 are shorter than the debounce window.
        base = pulse_cnt;
        pb_in_n = 1'b0; ticks(3);
        pb_in_n = 1'b1; ticks(2);
        pb_in_n = 1'b0; ticks(3);
        pb_in_n = 1'b1; ticks(12);
        chk("bounce_level_seen", 32'(lvl_seen), 0);
        chk("bounce_pulses", 32'(pulse_cnt - base), 0);
        chk("bounce_mode", 32'(mode_selection), 1);

        // Short press, 12 cycles.
        base = pulse_cnt; t0 = cyc;
        pb_in_n = 1'b0; ticks(12);
        t1 = cyc;
        pb_in_n = 1'b1; ticks(15);
        chk("short_rise_latency", 32'(rise_cyc - t0), 7);
        chk("short_fall_latency", 32'(fall_cyc - t1), 7);
        chk("short_pulses", 32'(pulse_cnt - base), 1);
        chk("short_pulse_time", 32'(last_pulse_cyc - fall_cyc), 1);
        chk("short_mode", 32'(mode_selection), 1);

        // Long press, 40 cycles (autorepeat build adds pulses at entry+8 and +16).
        base = pulse_cnt; t0 = cyc;
        pb_in_n = 1'b0; ticks(40);
        pb_in_n = 1'b1; ticks(15);
        chk("long1_mode", 32'(mode_selection), 0);
        chk("long1_toggle_time", 32'(mode_chg_cyc - rise_cyc), 20);
        chk("long1_toggle_abs", 32'(mode_chg_cyc - t0), 27);
        chk("long1_pulses", 32'(pulse_cnt - base), AR_ON ? 2 : 0);

        // Second long press restores mode.
        base = pulse_cnt;
        pb_in_n = 1'b0; ticks(40);
        pb_in_n = 1'b1; ticks(15);
        chk("long2_mode", 32'(mode_selection), 1);
        chk("long2_toggle_time", 32'(mode_chg_cyc - rise_cyc), 20);

        // Threshold race: pb_level falls the cycle hold_cnt reaches 19 -> short press.
        base = pulse_cnt;
        pb_in_n = 1'b0; ticks(19);
        pb_in_n = 1'b1; ticks(15);
        chk("race_level_width", 32'(fall_cyc - rise_cyc), 19);
        chk("race_pulses", 32'(pulse_cnt - base), 1);
        chk("race_pulse_time", 32'(last_pulse_cyc - fall_cyc), 1);
        chk("race_mode", 32'(mode_selection), 1);

        // One cycle longer: classified long.
        base = pulse_cnt;
        pb_in_n = 1'b0; ticks(20);
        pb_in_n = 1'b1; ticks(15);
        chk("bound20_mode", 32'(mode_selection), 0);
        chk("bound20_pulses", 32'(pulse_cnt - base), 0);
        chk("bound20_toggle_time", 32'(mode_chg_cyc - rise_cyc), 20);

        // Hold 60: LONG at t0+27; repeats (if built) at t0+35,43,51,59; the one at t0+67 meets the release.
        base = pulse_cnt; t0 = cyc;
        pb_in_n = 1'b0; ticks(60);
        pb_in_n = 1'b1; ticks(15);
        chk("hold60_mode", 32'(mode_selection), 1);
        chk("hold60_toggle_abs", 32'(mode_chg_cyc - t0), 27);
        chk("hold60_pulses", 32'(pulse_cnt - base), AR_ON ? 4 : 0);
`ifdef PB_AUTOREPEAT_EN
        chk("hold60_last_repeat", 32'(last_pulse_cyc - t0), 59);
`endif

        // Reset while held in LONG with mode 0.
        pb_in_n = 1'b0; ticks(30);
        chk("rstmid_pre_mode", 32'(mode_selection), 0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mode", 32'(mode_selection), 1);
        chk("rstmid_pulse", 32'(pb_pulse), 0);
        chk("rstmid_level", 32'(pb_level), 0);
        ticks(2);
        rst_n = 1'b1;
        r = cyc;
        ticks(10);
        chk("rstmid_repress_rise", 32'(rise_cyc - r), 7);
        base = pulse_cnt;
        t1 = cyc;
        pb_in_n = 1'b1; ticks(15);
        chk("rstmid_short_pulses", 32'(pulse_cnt - base), 1);
        chk("rstmid_pulse_time", 32'(last_pulse_cyc - t1), 8);
        chk("rstmid_mode_after", 32'(mode_selection), 1);

        chk("no_consecutive_pulse", 32'(consec), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
